// File: rtl/hub_pkg.sv
// Shared hub constants: requester count, address/data widths and derived
// slot-counter and byte-enable widths.
package hub_pkg;

  localparam int HUB_NUM_COGS = 8;
  localparam int HUB_AW       = 14;
  localparam int HUB_DW       = 32;
  localparam int HUB_BW       = HUB_DW / 8;
  localparam int HUB_SW       = $clog2(HUB_NUM_COGS);

endpackage

// File: rtl/hub_slot_mux.sv
// NUM_COGS:1 selector picking one cog's {w, wb, a, d} request fields by slot.
module hub_slot_mux
  import hub_pkg::*;
#(
  parameter int NUM_COGS = HUB_NUM_COGS,
  parameter int AW       = HUB_AW,
  parameter int DW       = HUB_DW,
  localparam int SW      = $clog2(NUM_COGS),
  localparam int BW      = DW / 8
) (
  input  logic [SW-1:0]          sel_i,
  input  logic [NUM_COGS-1:0]    cog_w_i,
  input  logic [NUM_COGS*BW-1:0] cog_wb_i,
  input  logic [NUM_COGS*AW-1:0] cog_a_i,
  input  logic [NUM_COGS*DW-1:0] cog_d_i,
  output logic                   sel_w_o,
  output logic [BW-1:0]          sel_wb_o,
  output logic [AW-1:0]          sel_a_o,
  output logic [DW-1:0]          sel_d_o
);

  always_comb begin
    sel_w_o  = cog_w_i[sel_i];
    sel_wb_o = cog_wb_i[sel_i*BW +: BW];
    sel_a_o  = cog_a_i[sel_i*AW +: AW];
    sel_d_o  = cog_d_i[sel_i*DW +: DW];
  end

endmodule

// File: rtl/hub_slot_arb.sv
// Round-robin hub slot arbiter: one cog owns the memory bus per ena_bus cycle;
// read data returns with a one-clock ack on the edge after issue.
module hub_slot_arb
  import hub_pkg::*;
#(
  parameter int NUM_COGS = HUB_NUM_COGS,
  parameter int AW       = HUB_AW,
  parameter int DW       = HUB_DW,
  localparam int SW      = $clog2(NUM_COGS),
  localparam int BW      = DW / 8
) (
  input  logic                   clk_cog,
  input  logic                   res,
  input  logic                   ena_bus,
  input  logic [NUM_COGS-1:0]    cog_req,
  input  logic [NUM_COGS-1:0]    cog_w,
  input  logic [NUM_COGS*BW-1:0] cog_wb,
  input  logic [NUM_COGS*AW-1:0] cog_a,
  input  logic [NUM_COGS*DW-1:0] cog_d,
  output logic                   mem_w,
  output logic [BW-1:0]          mem_wb,
  output logic [AW-1:0]          mem_a,
  output logic [DW-1:0]          mem_d,
  input  logic [DW-1:0]          mem_q,
  output logic [SW-1:0]          slot,
  output logic [NUM_COGS-1:0]    cog_ack,
  output logic [DW-1:0]          rdata
);

  logic [SW-1:0]       slot_q, slot_d;
  logic                pend_vld_q, pend_vld_d;
  logic [SW-1:0]       pend_cog_q, pend_cog_d;
  logic [NUM_COGS-1:0] cog_ack_q, cog_ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic                iss;
  logic                sel_w;
  logic [BW-1:0]       sel_wb;
  logic [AW-1:0]       sel_a;
  logic [DW-1:0]       sel_d;

  hub_slot_mux #(
    .NUM_COGS(NUM_COGS),
    .AW      (AW),
    .DW      (DW)
  ) u_mux (
    .sel_i   (slot_q),
    .cog_w_i (cog_w),
    .cog_wb_i(cog_wb),
    .cog_a_i (cog_a),
    .cog_d_i (cog_d),
    .sel_w_o (sel_w),
    .sel_wb_o(sel_wb),
    .sel_a_o (sel_a),
    .sel_d_o (sel_d)
  );

  // Address and data follow the slot owner every cycle; only the strobes are qualified.
  always_comb begin
    iss    = ena_bus & cog_req[slot_q];
    mem_w  = iss & sel_w;
    mem_wb = iss ? sel_wb : '0;
    mem_a  = sel_a;
    mem_d  = sel_d;
  end

  always_comb begin
    slot_d     = ena_bus ? slot_q + 1'b1 : slot_q;
    pend_vld_d = iss;
    pend_cog_d = iss ? slot_q : pend_cog_q;
    cog_ack_d  = '0;
    cog_ack_d[pend_cog_q] = pend_vld_q;
    rdata_d    = pend_vld_q ? mem_q : rdata_q;
  end

  // Reset drops any in-flight access without acking it.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      slot_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_cog_q <= '0;
      cog_ack_q  <= '0;
      rdata_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      pend_vld_q <= pend_vld_d;
      pend_cog_q <= pend_cog_d;
      cog_ack_q  <= cog_ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign slot    = slot_q;
  assign cog_ack = cog_ack_q;
  assign rdata   = rdata_q;

endmodule
